// File: rtl/uart_transmitter.sv
// UART transmitter: 8N1/8N2 framing with a one-entry holding register
// so back-to-back bytes go out with no idle gap between frames.
module uart_transmitter #(
  parameter int CLKS_PER_BIT = 868,
  parameter int STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       tx,
  output logic       tx_busy,
  output logic       tx_done
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [0:0]    SB_LAST  = 1'(STOP_BITS - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t        state_q;
  state_t        state_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic [2:0]    idx_q;
  logic [2:0]    idx_d;
  logic [0:0]    sb_q;
  logic [0:0]    sb_d;
  logic [7:0]    shift_q;
  logic [7:0]    shift_d;
  logic [7:0]    hold_q;
  logic          ready_q;
  logic          tx_q;
  logic          tx_d;
  logic          done_q;
  logic          done_d;
  logic          accept;
  logic          load;
  logic          bit_end;

  assign accept  = tx_valid && ready_q;
  assign bit_end = (cnt_q == CNT_LAST);

  assign tx_ready = ready_q;
  assign tx       = tx_q;
  assign tx_done  = done_q;
  assign tx_busy  = (state_q != IDLE) || !ready_q;

  // Holding register: filled on handshake, emptied when the shifter loads.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hold_q  <= 8'h00;
      ready_q <= 1'b1;
    end else if (load) begin
      ready_q <= 1'b1;
    end else if (accept) begin
      hold_q  <= tx_data;
      ready_q <= 1'b0;
    end
  end

  // Frame state register; tx and tx_done come straight from flops.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= 3'd0;
      sb_q    <= 1'b0;
      shift_q <= 8'h00;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      sb_q    <= sb_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      done_q  <= done_d;
    end
  end

  // Next-state: walk start, eight data bits LSB first, then stop bits.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    sb_d    = sb_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    done_d  = 1'b0;
    load    = 1'b0;
    unique case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (!ready_q) begin
          load    = 1'b1;
          shift_d = hold_q;
          state_d = START;
          cnt_d   = '0;
          tx_d    = 1'b0;
        end
      end
      START: begin
        if (bit_end) begin
          cnt_d   = '0;
          idx_d   = 3'd0;
          state_d = DATA;
          tx_d    = shift_q[0];
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DATA: begin
        if (bit_end) begin
          cnt_d = '0;
          if (idx_q == 3'd7) begin
            state_d = STOP;
            sb_d    = 1'b0;
            tx_d    = 1'b1;
          end else begin
            idx_d = idx_q + 3'd1;
            tx_d  = shift_q[idx_d];
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      STOP: begin
        if (bit_end) begin
          cnt_d = '0;
          if (sb_q == SB_LAST) begin
            done_d = 1'b1;
            sb_d   = 1'b0;
            if (!ready_q) begin
              load    = 1'b1;
              shift_d = hold_q;
              state_d = START;
              tx_d    = 1'b0;
            end else begin
              state_d = IDLE;
              tx_d    = 1'b1;
            end
          end else begin
            sb_d = sb_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_transmitter.sv
// Bench for uart_transmitter: random traffic scored against a
// per-cycle frame timeline model, plus directed edge cases.
module tb_uart_transmitter;

  localparam int C = 4;
  localparam int L = 10 * C;

  typedef struct {
    int         a;
    int         s;
    logic [7:0] d;
  } frame_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       v1 = 1'b0;
  logic [7:0] d1 = 8'h00;
  logic       r1, t1, b1, dn1;
  logic       v2 = 1'b0;
  logic [7:0] d2 = 8'h00;
  logic       r2, t2, b2, dn2;

  frame_t fq[$];
  int     n = 0;
  int     last_end = 0;
  bit     acc = 1'b0;
  int     errs = 0;
  int     checks = 0;

  always #5 clk = ~clk;

  uart_transmitter #(
    .CLKS_PER_BIT(C),
    .STOP_BITS(1)
  ) u_dut (
    .clk(clk),
    .reset(reset),
    .tx_valid(v1),
    .tx_data(d1),
    .tx_ready(r1),
    .tx(t1),
    .tx_busy(b1),
    .tx_done(dn1)
  );

  uart_transmitter #(
    .CLKS_PER_BIT(C),
    .STOP_BITS(2)
  ) u_dut2 (
    .clk(clk),
    .reset(reset),
    .tx_valid(v2),
    .tx_data(d2),
    .tx_ready(r2),
    .tx(t2),
    .tx_busy(b2),
    .tx_done(dn2)
  );

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               tag, got, exp, n);
    end
  endtask

  function automatic logic exp_tx(int c);
    int b;
    foreach (fq[i]) begin
      if (c >= fq[i].s && c < fq[i].s + L) begin
        b = (c - fq[i].s) / C;
        if (b == 0) return 1'b0;
        if (b <= 8) return fq[i].d[b-1];
        return 1'b1;
      end
    end
    return 1'b1;
  endfunction

  function automatic logic exp_done(int c);
    foreach (fq[i]) if (c == fq[i].s + L) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic exp_busy(int c);
    foreach (fq[i]) if (c >= fq[i].a && c < fq[i].s + L) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic exp_ready(int c);
    foreach (fq[i]) if (c >= fq[i].a && c < fq[i].s) return 1'b0;
    return 1'b1;
  endfunction

  task automatic step();
    bit     rdy;
    frame_t f;
    rdy = exp_ready(n);
    @(posedge clk);
    n++;
    acc = 1'b0;
    if (reset && v1 && rdy) begin
      f.a = n;
      f.s = (n + 1 > last_end) ? n + 1 : last_end;
      f.d = d1;
      fq.push_back(f);
      last_end = f.s + L;
      acc = 1'b1;
    end
    while (fq.size() > 0 && fq[0].s + L < n - 1) void'(fq.pop_front());
    @(negedge clk);
    chk("tx", t1, exp_tx(n));
    chk("ready", r1, exp_ready(n));
    chk("busy", b1, exp_busy(n));
    chk("done", dn1, exp_done(n));
  endtask

  task automatic send(logic [7:0] v);
    int k;
    k = 0;
    v1 = 1'b1;
    d1 = v;
    do begin
      step();
      k++;
    end while (!acc && k < 200);
    if (!acc) chk("accept_timeout", 0, 1);
    v1 = 1'b0;
  endtask

  task automatic do_reset(int k);
    reset = 1'b0;
    fq.delete();
    last_end = 0;
    #1;
    chk("rst_tx", t1, 1);
    chk("rst_done", dn1, 0);
    chk("rst_ready", r1, 1);
    chk("rst_busy", b1, 0);
    repeat (k) step();
    reset = 1'b1;
  endtask

  initial begin
    int s;
    int f;
    int lows;
    int his;
    int didx;
    int dcnt;
    logic rt[60];
    logic rd[60];
    logic rb[60];

    @(negedge clk);
    do_reset(3);
    repeat (100) step();

    send(8'hA5);
    while (n < last_end - 1) step();
    v1 = 1'b1;
    d1 = 8'h3C;
    step();
    chk("boundary_acc", acc, 1);
    v1 = 1'b0;
    repeat (50) step();

    send(8'h55);
    send(8'h0F);
    repeat (100) step();

    send(8'hFF);
    s = fq[fq.size()-1].s;
    while (n < s + 4 * C + 1) step();
    do_reset(5);
    send(8'h81);
    repeat (50) step();

    repeat (3000) begin
      if (!v1 || acc) begin
        v1 = ($urandom_range(0, 3) == 0);
        d1 = 8'($urandom);
      end
      step();
    end
    v1 = 1'b0;
    repeat (100) step();

    v2 = 1'b1;
    d2 = 8'h00;
    step();
    v2 = 1'b0;
    rt[0] = t2;
    rd[0] = dn2;
    rb[0] = b2;
    for (int i = 1; i < 60; i++) begin
      step();
      rt[i] = t2;
      rd[i] = dn2;
      rb[i] = b2;
    end
    f = -1;
    lows = 0;
    didx = -1;
    dcnt = 0;
    for (int i = 0; i < 60; i++) begin
      if (rt[i] == 1'b0) begin
        lows++;
        if (f < 0) f = i;
      end
      if (rd[i]) begin
        dcnt++;
        if (didx < 0) didx = i;
      end
    end
    his = 0;
    if (f >= 0) begin
      for (int i = f + 36; i < f + 44 && i < 60; i++) begin
        if (rt[i] == 1'b1) his++;
      end
    end
    chk("s2_latency", f, 1);
    chk("s2_low", lows, 36);
    chk("s2_stop_hi", his, 8);
    chk("s2_done_at", didx - f, 44);
    chk("s2_done_cnt", dcnt, 1);
    if (f >= 0 && f + 45 < 60) chk("s2_busy_after", rb[f+45], 0);
    else chk("s2_busy_after", 1, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
